// File: rtl/dbuf_scheduler_if.sv
// dbuf_scheduler_if: all non-clock signals of the ping-pong frame-buffer
// scheduler, grouped as one bundle.
//   slave  : scheduler side (takes wr_valid/vsync/rd_req, drives the rest)
//   master : environment side (frame source + display timing + memories)
// Write path : wr_valid, wr_ready, WE0, WE1, wr_addr
// Read path  : vsync, rd_req, RE0, RE1, rd_addr
// Mux/status : SelBuf0, SelBuf1, SelBlank, Buf0Empty, Buf1Empty, underrun
interface dbuf_scheduler_if #(
  parameter int ADDR_W = 20
);
  logic              wr_valid;
  logic              wr_ready;
  logic              WE0;
  logic              WE1;
  logic [ADDR_W-1:0] wr_addr;
  logic              vsync;
  logic              rd_req;
  logic              RE0;
  logic              RE1;
  logic [ADDR_W-1:0] rd_addr;
  logic              SelBuf0;
  logic              SelBuf1;
  logic              SelBlank;
  logic              Buf0Empty;
  logic              Buf1Empty;
  logic              underrun;

  modport slave (
    input  wr_valid, vsync, rd_req,
    output wr_ready, WE0, WE1, wr_addr, RE0, RE1, rd_addr,
           SelBuf0, SelBuf1, SelBlank, Buf0Empty, Buf1Empty, underrun
  );

  modport master (
    output wr_valid, vsync, rd_req,
    input  wr_ready, WE0, WE1, wr_addr, RE0, RE1, rd_addr,
           SelBuf0, SelBuf1, SelBlank, Buf0Empty, Buf1Empty, underrun
  );
endinterface

// File: rtl/dbuf_scheduler.sv
// dbuf_scheduler: ping-pong scheduler for two display frame buffers.
// Steers the incoming word stream into the free buffer, hands full buffers
// to the display scan at vsync, and drives write/read enables, addresses,
// output-mux selects and empty flags.
// Ports:
//   clk          system clock (posedge)
//   reset        synchronous, active-high
//   bus          dbuf_scheduler_if.slave (write path, read path, mux/status)
//   underrun_cnt 16-bit saturating underrun count, only when
//                DBUF_UNDERRUN_CNT_EN is defined
// Build option: define DBUF_UNDERRUN_CNT_EN to add the underrun counter.
module dbuf_scheduler #(
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  dbuf_scheduler_if.slave        bus
`ifdef DBUF_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    SHOW    = 2'd3
  } buf_st_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

  buf_st_e           st_q [2];
  buf_st_e           st_d [2];
  logic              wbuf_q, wbuf_d;
  logic              rbuf_q, rbuf_d;
  logic              active_q, active_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              sel0_q, sel0_d;
  logic              sel1_q, sel1_d;
  logic              blank_q, blank_d;
  logic              emp0_q, emp0_d;
  logic              emp1_q, emp1_d;
  logic              und_q, und_d;
  logic              cand;
  logic              wr_ready;
  logic              accept;
  logic              we0, we1, re0, re1;
`ifdef DBUF_UNDERRUN_CNT_EN
  logic [15:0]       cnt_q, cnt_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wbuf_q    <= 1'b0;
      rbuf_q    <= 1'b0;
      active_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      sel0_q    <= 1'b0;
      sel1_q    <= 1'b0;
      blank_q   <= 1'b1;
      emp0_q    <= 1'b1;
      emp1_q    <= 1'b1;
      und_q     <= 1'b0;
`ifdef DBUF_UNDERRUN_CNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wbuf_q    <= wbuf_d;
      rbuf_q    <= rbuf_d;
      active_q  <= active_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      sel0_q    <= sel0_d;
      sel1_q    <= sel1_d;
      blank_q   <= blank_d;
      emp0_q    <= emp0_d;
      emp1_q    <= emp1_d;
      und_q     <= und_d;
`ifdef DBUF_UNDERRUN_CNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state logic. A write only ever touches the buffer in EMPTY/FILLING,
  // a vsync only the buffers in FULL/SHOW, so the two never collide.
  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wbuf_d    = wbuf_q;
    rbuf_d    = rbuf_q;
    active_d  = active_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    und_d     = 1'b0;
    // While showing, the next frame lives in the other buffer; before the
    // first frame, rbuf still points at the buffer filled first.
    cand      = active_q ? ~rbuf_q : rbuf_q;

    if (accept) begin
      if (wr_addr_q == LAST) begin
        st_d[wbuf_q] = FULL;
        wr_addr_d    = '0;
        wbuf_d       = ~wbuf_q;
      end else begin
        st_d[wbuf_q] = FILLING;
        wr_addr_d    = wr_addr_q + ADDR_W'(1);
      end
    end

    if (bus.vsync) begin
      rd_addr_d = '0;
      // Decided on registered state: a frame finishing on this edge waits.
      if (st_q[cand] == FULL) begin
        if (active_q) st_d[rbuf_q] = EMPTY;
        st_d[cand] = SHOW;
        rbuf_d     = cand;
        active_d   = 1'b1;
      end else begin
        und_d = 1'b1;
      end
    end else if (bus.rd_req && active_q && (rd_addr_q != LAST)) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end

    sel0_d  = active_d & ~rbuf_d;
    sel1_d  = active_d &  rbuf_d;
    blank_d = ~active_d;
    emp0_d  = (st_d[0] == EMPTY);
    emp1_d  = (st_d[1] == EMPTY);

`ifdef DBUF_UNDERRUN_CNT_EN
    cnt_d = (und_d && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
`endif
  end

  // Combinational outputs
  always_comb begin
    wr_ready = (st_q[wbuf_q] == EMPTY) || (st_q[wbuf_q] == FILLING);
    accept   = bus.wr_valid & wr_ready;
    we0      = accept & ~wbuf_q;
    we1      = accept &  wbuf_q;
    re0      = bus.rd_req & active_q & ~rbuf_q;
    re1      = bus.rd_req & active_q &  rbuf_q;
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.WE0       = we0;
  assign bus.WE1       = we1;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.RE0       = re0;
  assign bus.RE1       = re1;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.SelBuf0   = sel0_q;
  assign bus.SelBuf1   = sel1_q;
  assign bus.SelBlank  = blank_q;
  assign bus.Buf0Empty = emp0_q;
  assign bus.Buf1Empty = emp1_q;
  assign bus.underrun  = und_q;
`ifdef DBUF_UNDERRUN_CNT_EN
  assign underrun_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_dbuf_scheduler.sv
// Bench for dbuf_scheduler with FRAME_WORDS=4: directed vector table,
// hand-written corner sequences, then random traffic against a frame-level
// model (ready-frame queue + shown-buffer index).
module tb_dbuf_scheduler;
  localparam int FW = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbuf_scheduler_if #(.ADDR_W(AW)) bus ();
`ifdef DBUF_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  dbuf_scheduler #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DBUF_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model: buffer being shown (-1 = blank), queue of completed
  // frames waiting for vsync, buffer being filled and words written so far.
  int m_shown, m_wbuf, m_wcnt, m_rd, m_cnt;
  int m_ready[$];
  bit m_und;

  logic           p_rdy;
  logic [1:0]     p_we, p_re;
  logic [AW-1:0]  p_wa, p_ra;

  typedef struct {
    logic wv, vs, rq;
    logic rdy;
    logic [1:0] we, re;
    logic [3:0] wa, ra;
    logic [2:0] sel;  // {blank, buf1, buf0}
    logic [1:0] emp;  // {buf1, buf0}
    logic und;
  } vec_t;
  vec_t tbl[$];

  task automatic m_reset();
    m_shown = -1; m_ready.delete(); m_wbuf = 0; m_wcnt = 0; m_rd = 0;
    m_und = 0; m_cnt = 0;
  endtask

  function automatic bit m_queued(int b);
    foreach (m_ready[i]) if (m_ready[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_sel();
    if (m_shown < 0) return 3'b100;
    return (m_shown == 0) ? 3'b001 : 3'b010;
  endfunction

  function automatic logic m_empty(int b);
    return !((m_shown == b) || m_queued(b) || (m_wbuf == b && m_wcnt > 0));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] dut_sel();
    return {bus.SelBlank, bus.SelBuf1, bus.SelBuf0};
  endfunction

  function automatic logic [1:0] dut_emp();
    return {bus.Buf1Empty, bus.Buf0Empty};
  endfunction

  // One clock: drive, check combinational outputs vs model, clock,
  // advance model, check registered outputs. Returns at posedge+1.
  task automatic step(input logic r, input logic wv, input logic vs, input logic rq);
    logic rdy;
    reset = r; bus.wr_valid = wv; bus.vsync = vs; bus.rd_req = rq;
    #2;
    rdy   = !((m_shown == m_wbuf) || m_queued(m_wbuf));
    p_rdy = bus.wr_ready;
    p_we  = {bus.WE1, bus.WE0};
    p_re  = {bus.RE1, bus.RE0};
    p_wa  = bus.wr_addr;
    p_ra  = bus.rd_addr;
    chk("wr_ready", 32'(p_rdy), 32'(rdy));
    chk("we", 32'(p_we), 32'({wv & rdy & (m_wbuf == 1), wv & rdy & (m_wbuf == 0)}));
    chk("re", 32'(p_re), 32'({rq & (m_shown == 1), rq & (m_shown == 0)}));
    chk("wr_addr", 32'(p_wa), 32'(m_wcnt));
    chk("rd_addr", 32'(p_ra), 32'(m_rd));
    @(posedge clk);
    if (r) m_reset();
    else begin
      m_und = 0;
      if (vs) begin
        m_rd = 0;
        if (m_ready.size() > 0) m_shown = m_ready.pop_front();
        else m_und = 1;
      end else if (rq && m_shown >= 0 && m_rd < FW - 1) m_rd++;
      if (wv && rdy) begin
        m_wcnt++;
        if (m_wcnt == FW) begin
          m_ready.push_back(m_wbuf);
          m_wbuf ^= 1;
          m_wcnt = 0;
        end
      end
      if (m_und && m_cnt < 65535) m_cnt++;
    end
    #1;
    chk("sel", 32'(dut_sel()), 32'(m_sel()));
    chk("empty", 32'(dut_emp()), 32'({m_empty(1), m_empty(0)}));
    chk("underrun", 32'(bus.underrun), 32'(m_und));
`ifdef DBUF_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic add(input logic wv, vs, rq, rdy, input logic [1:0] we, re,
                     input logic [3:0] wa, ra, input logic [2:0] sel,
                     input logic [1:0] emp, input logic und);
    vec_t v;
    v.wv = wv; v.vs = vs; v.rq = rq; v.rdy = rdy; v.we = we; v.re = re;
    v.wa = wa; v.ra = ra; v.sel = sel; v.emp = emp; v.und = und;
    tbl.push_back(v);
  endtask

  initial begin
    //  wv vs rq | rdy we     re     wa ra | sel     emp    und
    add(0, 1, 0,  1, 2'b00, 2'b00, 0, 0,  3'b100, 2'b11, 1); // vsync, nothing ready
    add(0, 0, 1,  1, 2'b00, 2'b00, 0, 0,  3'b100, 2'b11, 0); // rd_req while blank
    add(1, 0, 0,  1, 2'b01, 2'b00, 0, 0,  3'b100, 2'b10, 0); // fill buf0
    add(1, 0, 0,  1, 2'b01, 2'b00, 1, 0,  3'b100, 2'b10, 0);
    add(1, 0, 0,  1, 2'b01, 2'b00, 2, 0,  3'b100, 2'b10, 0);
    add(1, 0, 0,  1, 2'b01, 2'b00, 3, 0,  3'b100, 2'b10, 0);
    add(0, 1, 0,  1, 2'b00, 2'b00, 0, 0,  3'b001, 2'b10, 0); // show buf0
    add(0, 0, 1,  1, 2'b00, 2'b01, 0, 0,  3'b001, 2'b10, 0); // scan
    add(0, 0, 1,  1, 2'b00, 2'b01, 0, 1,  3'b001, 2'b10, 0);
    add(0, 0, 1,  1, 2'b00, 2'b01, 0, 2,  3'b001, 2'b10, 0);
    add(0, 0, 1,  1, 2'b00, 2'b01, 0, 3,  3'b001, 2'b10, 0);
    add(0, 0, 1,  1, 2'b00, 2'b01, 0, 3,  3'b001, 2'b10, 0); // saturates
    add(0, 0, 0,  1, 2'b00, 2'b00, 0, 3,  3'b001, 2'b10, 0);
    add(1, 0, 0,  1, 2'b10, 2'b00, 0, 3,  3'b001, 2'b00, 0); // buf1 partial
    add(0, 1, 0,  1, 2'b00, 2'b00, 1, 3,  3'b001, 2'b00, 1); // repeat frame
    add(0, 0, 1,  1, 2'b00, 2'b01, 1, 0,  3'b001, 2'b00, 0);
    add(1, 0, 0,  1, 2'b10, 2'b00, 1, 1,  3'b001, 2'b00, 0);
    add(1, 0, 0,  1, 2'b10, 2'b00, 2, 1,  3'b001, 2'b00, 0);
    add(1, 0, 0,  1, 2'b10, 2'b00, 3, 1,  3'b001, 2'b00, 0); // buf1 full
    add(1, 0, 0,  0, 2'b00, 2'b00, 0, 1,  3'b001, 2'b00, 0); // backpressure
    add(1, 1, 0,  0, 2'b00, 2'b00, 0, 1,  3'b010, 2'b01, 0); // swap
    add(1, 0, 0,  1, 2'b01, 2'b00, 0, 0,  3'b010, 2'b00, 0);
    add(0, 0, 1,  1, 2'b00, 2'b10, 1, 0,  3'b010, 2'b00, 0);

    reset = 1'b1; bus.wr_valid = 1'b0; bus.vsync = 1'b0; bus.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    chk("rst_sel", 32'(dut_sel()), 32'(3'b100));
    chk("rst_empty", 32'(dut_emp()), 32'(2'b11));
    chk("rst_underrun", 32'(bus.underrun), 32'(0));
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'(0));
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'(1));

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].wv, tbl[i].vs, tbl[i].rq);
      chk($sformatf("t%0d_rdy", i), 32'(p_rdy), 32'(tbl[i].rdy));
      chk($sformatf("t%0d_we", i), 32'(p_we), 32'(tbl[i].we));
      chk($sformatf("t%0d_re", i), 32'(p_re), 32'(tbl[i].re));
      chk($sformatf("t%0d_wa", i), 32'(p_wa), 32'(tbl[i].wa));
      chk($sformatf("t%0d_ra", i), 32'(p_ra), 32'(tbl[i].ra));
      chk($sformatf("t%0d_sel", i), 32'(dut_sel()), 32'(tbl[i].sel));
      chk($sformatf("t%0d_emp", i), 32'(dut_emp()), 32'(tbl[i].emp));
      chk($sformatf("t%0d_und", i), 32'(bus.underrun), 32'(tbl[i].und));
    end

    // Both buffers filled with no vsync: 9th word is held off.
    step(1'b1, 0, 0, 0);
    repeat (8) step(1'b0, 1, 0, 0);
    step(1'b0, 1, 0, 0);
    chk("fill9_rdy", 32'(p_rdy), 32'(0));
    chk("fill9_we", 32'(p_we), 32'(0));
    step(1'b0, 0, 1, 0);
    chk("fill_vs1_sel", 32'(dut_sel()), 32'(3'b001));
    chk("fill_vs1_emp", 32'(dut_emp()), 32'(2'b00));
    step(1'b0, 0, 1, 0);
    chk("fill_vs2_sel", 32'(dut_sel()), 32'(3'b010));
    chk("fill_vs2_emp", 32'(dut_emp()), 32'(2'b01));
    step(1'b0, 0, 0, 0);
    chk("fill_vs2_rdy", 32'(p_rdy), 32'(1));

    // Frame completes on the vsync edge: not shown until the next vsync.
    step(1'b1, 0, 0, 0);
    repeat (3) step(1'b0, 1, 0, 0);
    step(1'b0, 1, 1, 0);
    chk("late_und", 32'(bus.underrun), 32'(1));
    chk("late_sel", 32'(dut_sel()), 32'(3'b100));
    chk("late_emp", 32'(dut_emp()), 32'(2'b10));
    step(1'b0, 0, 1, 0);
    chk("late_vs2_sel", 32'(dut_sel()), 32'(3'b001));
    chk("late_vs2_und", 32'(bus.underrun), 32'(0));

    // Reset mid-fill aborts the partial frame.
    step(1'b1, 0, 0, 0);
    repeat (2) step(1'b0, 1, 0, 0);
    step(1'b0, 0, 0, 0);
    chk("mid_wa", 32'(p_wa), 32'(2));
    step(1'b1, 1, 0, 0);
    chk("mid_sel", 32'(dut_sel()), 32'(3'b100));
    chk("mid_emp", 32'(dut_emp()), 32'(2'b11));
    chk("mid_und", 32'(bus.underrun), 32'(0));
    step(1'b0, 0, 0, 0);
    chk("mid_wa0", 32'(p_wa), 32'(0));
    chk("mid_rdy", 32'(p_rdy), 32'(1));
`ifdef DBUF_UNDERRUN_CNT_EN
    repeat (3) step(1'b0, 0, 1, 0);
    step(1'b0, 0, 0, 0);
    chk("cnt3", 32'(underrun_cnt), 32'(3));
    step(1'b1, 0, 0, 0);
    chk("cnt_rst", 32'(underrun_cnt), 32'(0));
`endif

    // Random traffic against the model.
    repeat (800) begin
      step(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
